// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width, input int chunk);
    return $clog2(width / chunk);
  endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// fa_slice: CHUNK-wide combinational ripple adder, one chunk per cycle.
module fa_slice #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] s_chunk,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ c[i];
    assign c[i+1] = (a_chunk[i] & b_chunk[i]) |
                    (c[i] & (a_chunk[i] ^ b_chunk[i]));
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Serial adder: CHUNK bits per cycle, LSB first, IDLE/RUN/DONE FSM.
// SERIAL_ADDER_SUB_EN adds a sub input (a + ~b + 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(WIDTH, CHUNK) + 1;

  if (WIDTH % CHUNK != 0) begin : g_chk
    $error("serial_adder: WIDTH must be a multiple of CHUNK");
  end

  logic sub_w;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] s_chunk;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] s_ext;

  fa_slice #(.CHUNK(CHUNK)) u_fa (
    .a_chunk (a_q[CHUNK-1:0]),
    .b_chunk (b_q[CHUNK-1:0]),
    .cin     (carry_q),
    .s_chunk (s_chunk),
    .cout    (c_out),
    .c_msb   (c_msb)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    ovf_pend_d = ovf_pend_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    s_ext      = '0;
    s_ext[CHUNK-1:0] = s_chunk;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          a_d        = a;
          b_d        = sub_w ? ~b : b;
          carry_d    = sub_w ? 1'b1 : cin;
          acc_d      = '0;
          ovf_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Extra cycle after the last chunk publishes the result.
        if (cnt_q == CW'(N)) begin
          state_d = DONE;
          sum_d   = acc_q;
          cout_d  = carry_q;
          ovf_d   = ovf_pend_q;
        end else begin
          a_d     = a_q >> CHUNK;
          b_d     = b_q >> CHUNK;
          acc_d   = (acc_q >> CHUNK) | (s_ext << (WIDTH - CHUNK));
          carry_d = c_out;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            ovf_pend_d = c_msb ^ c_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      ovf_pend_q <= ovf_pend_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit/1-bit-chunk and 16-bit/4-bit-chunk.
module tb_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  exp_t q8[$];
  exp_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start8),
    .a        (a8),
    .b        (b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub8),
`endif
    .cin      (cin8),
    .busy     (busy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .a        (a16),
    .b        (b16),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub16),
`endif
    .cin      (cin16),
    .busy     (busy16),
    .done     (done16),
    .sum      (sum16),
    .cout     (cout16),
    .overflow (ovf16)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic reference.
  function automatic exp_t model(input int w, input logic [15:0] a,
                                 input logic [15:0] b, input logic c,
                                 input logic s);
    exp_t   e;
    longint mask, aa, bb, t;
    logic   sa, sb, ss;
    mask = (64'sd1 <<< w) - 1;
    aa = longint'(a) & mask;
    bb = s ? (~longint'(b)) & mask : longint'(b) & mask;
    t = aa + bb + (s ? 64'sd1 : longint'(c));
    e.sum = 16'(t & mask);
    e.cout = ((t >>> w) & 1) != 0;
    sa = ((aa >>> (w - 1)) & 1) != 0;
    sb = ((bb >>> (w - 1)) & 1) != 0;
    ss = ((t >>> (w - 1)) & 1) != 0;
    e.ovf = (sa == sb) && (ss != sa);
    e.cyc = 0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input int d, input logic [15:0] a,
                       input logic [15:0] b, input logic c,
                       input logic s);
    exp_t e;
    int   k;
    k = 0;
    while ((d == 0 ? busy8 : busy16) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout dut %0d", d);
    end
    e = model(d == 0 ? 8 : 16, a, b, c, s);
    e.cyc = cyc + (d == 0 ? 8 : 4) + 2;
    if (d == 0) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c; sub8 = s; start8 = 1'b1;
      q8.push_back(e);
    end else begin
      a16 = a; b16 = b; cin16 = c; sub16 = s; start16 = 1'b1;
      q16.push_back(e);
    end
    @(negedge clk);
    if (d == 0) start8 = 1'b0;
    else start16 = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e.sum[7:0]));
        chk("cout8", 32'(cout8), 32'(e.cout));
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
        chk("done8_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q16.pop_front();
        chk("sum16", 32'(sum16), 32'(e.sum));
        chk("cout16", 32'(cout16), 32'(e.cout));
        chk("ovf16", 32'(ovf16), 32'(e.ovf));
        chk("done16_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((q8.size() != 0 || q16.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d %0d", q8.size(), q16.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_sum16", 32'(sum16), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 16'h0F, 16'h01, 1'b0, 1'b0);
    chk("busy_after_start", 32'(busy8), 32'd1);
    drain();

    issue(0, 16'hFF, 16'h01, 1'b0, 1'b0);
    issue(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    drain();

    // Second start at edge 3 lands while busy and must be dropped.
    issue(0, 16'h0F, 16'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain();

    // Reset after edge 4 of an operation.
    issue(0, 16'hAA, 16'h54, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy8), 32'd0);
    chk("midrst_sum", 32'(sum8), 32'd0);
    chk("midrst_done", 32'(done8), 32'd0);
    q8.delete();
    q16.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done8), 32'd0);
    end

    issue(0, 16'h3C, 16'h0A, 1'b1, 1'b0);
    issue(1, 16'h1234, 16'h0FFF, 1'b1, 1'b0);
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    issue(0, 16'h05, 16'h07, 1'b0, 1'b1);
    issue(1, 16'h8000, 16'h0001, 1'b1, 1'b1);
    drain();
`endif

    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic s;
`ifdef SERIAL_ADDER_SUB_EN
          s = 1'($urandom);
`else
          s = 1'b0;
`endif
          issue(0, 16'($urandom), 16'($urandom), 1'($urandom), s);
          repeat ($urandom_range(0, 12)) @(negedge clk);
        end
      end
      begin
        for (int j = 0; j < 20; j++) begin
          logic s;
`ifdef SERIAL_ADDER_SUB_EN
          s = 1'($urandom);
`else
          s = 1'b0;
`endif
          issue(1, 16'($urandom), 16'($urandom), 1'($urandom), s);
          repeat ($urandom_range(0, 6)) @(negedge clk);
        end
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 1: bits added per cycle; WIDTH % CHUNK == 0 is required, otherwise elaboration fails.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to begin an addition.
REQ-006 SHALL have port a, input, WIDTH: operand A, sampled with start.
REQ-007 SHALL have port b, input, WIDTH: operand B, sampled with start.
REQ-008 SHALL have port cin, input, 1: carry-in, sampled with start.
REQ-009 SHALL have port busy, output, 1: addition in progress.
REQ-010 SHALL have port done, output, 1: one-cycle result-valid pulse.
REQ-011 SHALL have port sum, output, WIDTH: registered result.
REQ-012 SHALL have port cout, output, 1: carry out of the MSB.
REQ-013 SHALL have port overflow, output, 1: two's-complement overflow of the result.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 Start acceptance SHALL occur whenever busy == 0 (IDLE or DONE): latch a, b and cin, clear the chunk counter, and go to RUN.
REQ-016 RUN SHALL add CHUNK bits per cycle, LSB chunk first, with carry propagated between chunks in a register, for N = WIDTH/CHUNK cycles.
REQ-017 Timing: with start sampled at edge 0, busy SHALL be high after edges 1..N, and done high for exactly the cycle after edge N+1.
REQ-018 sum, cout and overflow SHALL update only at the edge that raises done, and SHALL be held until the next completion.
REQ-019 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-020 start while busy == 1 SHALL be ignored: no operand change and no restart.
REQ-021 start during the DONE cycle SHALL be accepted; back-to-back operations SHALL therefore have a period of N+1 cycles.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH, with carry beyond the MSB reported only on cout.
REQ-023 CHUNK == WIDTH SHALL be legal: N = 1 and done at edge 2.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, busy 0, done 0, sum 0, cout 0, overflow 0, internal registers 0.
REQ-025 Reset mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start after release SHALL behave per REQ-017.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN SHALL control subtraction support.
REQ-028 Defined: the module SHALL add input port sub (1 bit, sampled with start); sub = 1 SHALL compute a + ~b + 1, ignoring cin; cout = 1 SHALL mean no borrow.
REQ-029 Undefined: the sub port SHALL be absent and the module SHALL perform addition only.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and a function computing the counter width $clog2(WIDTH/CHUNK).
REQ-031 Sub-module fa_slice SHALL be a CHUNK-wide combinational ripple adder (a_chunk, b_chunk, cin -> s_chunk, cout, carry-into-MSB); it SHALL be instantiated once and reused each cycle.

Verification
REQ-032 Bench SHALL cover: WIDTH=8, CHUNK=1, a=0x0F, b=0x01, cin=0, start at edge 0 -> done after edge 9 only, sum=0x10, cout=0, overflow=0.
REQ-033 Bench SHALL cover: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; then a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
REQ-034 Bench SHALL cover: start pulsed again at edge 3 with a=0x00, b=0x00 -> ignored; result = first operands, done still after edge 9.
REQ-035 Bench SHALL cover: rst_n low at edge 4 of an operation -> busy=0 and sum=0 immediately, with no done for 20 cycles.
REQ-036 Bench SHALL cover: WIDTH=16, CHUNK=4, a=0x1234, b=0x0FFF, cin=1 -> done after edge 5, sum=0x2234, cout=0.
REQ-037 Bench SHALL cover, with SERIAL_ADDER_SUB_EN defined: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, overflow=0.
